// File: rtl/iomem_pkg.sv
// Shared definitions for the PicoSoC iomem bus-master side.
package iomem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]  WSTRB_READ = 4'b0000;
  localparam logic [31:0] GPIO_BASE  = 32'h0300_0000;
  // Top address byte selecting the iomem peripheral window.
  localparam logic [7:0]  IOMEM_SEL  = 8'h03;

endpackage

// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus master: valid/ready command in, valid/ready
// response out, with a saturating timeout on the responder handshake.
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TO_LASTI = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LASTI);

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic addr_lsb_unused;
  assign addr_lsb_unused = ^cmd_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = {cmd_addr[31:2], 2'b00};
          wdata_d = cmd_wdata;
          wstrb_d = cmd_write ? cmd_wstrb : WSTRB_READ;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // Ready takes priority over a timeout landing in the same cycle.
        if (iomem_ready) begin
          rdata_d = (wstrb_q == WSTRB_READ) ? iomem_rdata : '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE) && !reset;
  assign iomem_valid = (state_q == BUS);
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign iomem_wstrb = wstrb_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;

endmodule
